// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader: packs an LSB-first bit stream into N-bit words
// behind a one-word output register, with sof-based resynchronisation.
module serial_word_loader #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         sin_sof,
    output logic         sin_ready,
    output logic [N-1:0] word,
    output logic         word_valid,
    input  logic         word_ready,
    output logic         frame_err
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_FILL,
        ST_FULL
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [N-1:0]   word_q, word_d;
    logic           word_valid_q, word_valid_d;
    logic           frame_err_q, frame_err_d;

    logic           accept;
    logic           restart;
    logic [CW-1:0]  idx;
    logic [N-1:0]   assembled;
    logic           load;
    logic           pop;

    // sin_ready decodes the state register only, so word_ready never reaches it combinationally.
    assign sin_ready  = (state_q == ST_FILL);
    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        frame_err_d  = 1'b0;
        load         = 1'b0;

        accept  = sin_valid && (state_q == ST_FILL);
        restart = accept && sin_sof && (cnt_q != '0);
        pop     = word_valid_q && word_ready;

        // A sof in mid-word drops the partial bits and restarts at bit 0.
        idx       = restart ? '0 : cnt_q;
        assembled = restart ? '0 : sr_q;
        assembled[idx] = sin;

        unique case (state_q)
            ST_INIT: begin
                state_d = ST_FILL;
            end
            ST_FILL: begin
                if (accept) begin
                    frame_err_d = restart;
                    if (idx == LAST_IDX) begin
                        cnt_d = '0;
                        if (!word_valid_q || word_ready) begin
                            load   = 1'b1;
                            word_d = assembled;
                            sr_d   = '0;
                        end else begin
                            sr_d    = assembled;
                            state_d = ST_FULL;
                        end
                    end else begin
                        sr_d  = assembled;
                        cnt_d = idx + CW'(1);
                    end
                end
            end
            ST_FULL: begin
                // The output register is necessarily occupied here; move the held word once it drains.
                if (word_ready) begin
                    load    = 1'b1;
                    word_d  = sr_q;
                    sr_d    = '0;
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (load) begin
            word_valid_d = 1'b1;
        end else if (pop) begin
            word_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            sr_q         <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed and randomized checks of serial_word_loader against a word-level scoreboard.
module tb_serial_word_loader;

    localparam int N      = 8;
    localparam int NWORDS = 1000;
    localparam int BUDGET = 60000;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic         sin_valid;
    logic         sin_sof;
    logic         sin_ready;
    logic [N-1:0] word;
    logic         word_valid;
    logic         word_ready;
    logic         frame_err;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] sent [NWORDS];

    serial_word_loader #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sin_sof    (sin_sof),
        .sin_ready  (sin_ready),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input logic sof);
        sin       = b;
        sin_sof   = sof;
        sin_valid = 1'b1;
        tick();
    endtask

    task automatic idle();
        sin_valid = 1'b0;
        sin_sof   = 1'b0;
        sin       = 1'b0;
    endtask

    initial begin
        logic [N-1:0] pat;
        logic [N-1:0] prev_word;
        logic         prev_stall;
        int           tx_w, tx_b, rx_w, cyc;

        rst = 1'b1; word_ready = 1'b0;
        idle();
        tick(); tick();
        check("rst_sin_ready", sin_ready, 0);
        check("rst_word", word, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        tick();
        check("post_rst_sin_ready", sin_ready, 1);

        // LSB-first packing of 1,0,1,1,0,0,0,1 with a ready consumer.
        word_ready = 1'b1;
        pat = 8'b1000_1101;
        for (int i = 0; i < N; i++) begin
            drive_bit(pat[i], i == 0);
            if (i == N - 2) check("8d_not_early", word_valid, 0);
        end
        idle();
        check("8d_valid", word_valid, 1);
        check("8d_word", word, 8'h8D);
        tick();
        check("8d_valid_one_cycle", word_valid, 0);

        // Back-to-back words with no bubble.
        for (int w = 0; w < 3; w++) begin
            pat = N'($urandom);
            for (int i = 0; i < N; i++) begin
                check("stream_sin_ready", sin_ready, 1);
                drive_bit(pat[i], i == 0);
                check("stream_valid", word_valid, i == N - 1);
                if (i == N - 1) check("stream_word", word, pat);
            end
        end
        idle();
        tick();

        // Stall: A5 sits in the output, 3C is held internally.
        word_ready = 1'b0;
        pat = 8'hA5;
        for (int i = 0; i < N; i++) drive_bit(pat[i], i == 0);
        check("a5_valid", word_valid, 1);
        check("a5_word", word, 8'hA5);
        pat = 8'h3C;
        for (int i = 0; i < N; i++) drive_bit(pat[i], i == 0);
        check("full_sin_ready", sin_ready, 0);
        check("full_word_held", word, 8'hA5);
        for (int i = 0; i < 3; i++) drive_bit(1'($urandom), 1'b1);
        idle();
        check("full_ignores_input_ready", sin_ready, 0);
        check("full_ignores_input_word", word, 8'hA5);
        check("full_no_frame_err", frame_err, 0);
        word_ready = 1'b1;
        tick();
        check("3c_valid_continuous", word_valid, 1);
        check("3c_word", word, 8'h3C);
        check("3c_sin_ready_back", sin_ready, 1);
        tick();
        check("3c_consumed", word_valid, 0);

        // Mid-word sof: three stray bits discarded, then FF.
        word_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive_bit(1'b0, i == 0);
        check("sof_no_partial_valid", word_valid, 0);
        check("sof_no_err_at_start", frame_err, 0);
        drive_bit(1'b1, 1'b1);
        check("sof_frame_err_pulse", frame_err, 1);
        for (int i = 0; i < N - 1; i++) begin
            drive_bit(1'b1, 1'b0);
            if (i == 0) check("sof_frame_err_single", frame_err, 0);
        end
        idle();
        check("sof_ff_valid", word_valid, 1);
        check("sof_ff_word", word, 8'hFF);
        word_ready = 1'b1;
        tick();
        check("sof_ff_consumed", word_valid, 0);

        // Reset with an output word and five buffered bits.
        word_ready = 1'b0;
        pat = 8'h5A;
        for (int i = 0; i < N; i++) drive_bit(pat[i], i == 0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1, i == 0);
        idle();
        check("pre_rst_valid", word_valid, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_word", word, 0);
        check("mid_rst_valid", word_valid, 0);
        check("mid_rst_sin_ready", sin_ready, 0);
        check("mid_rst_frame_err", frame_err, 0);
        rst = 1'b0;
        tick();
        check("mid_rst_ready_back", sin_ready, 1);
        pat = 8'hC3;
        for (int i = 0; i < N; i++) drive_bit(pat[i], 1'b0);
        idle();
        check("clean_word_valid", word_valid, 1);
        check("clean_word", word, 8'hC3);
        check("clean_no_frame_err", frame_err, 0);
        word_ready = 1'b1;
        tick();

        // Random traffic against an in-order scoreboard of sent words.
        for (int i = 0; i < NWORDS; i++) sent[i] = N'($urandom);
        tx_w = 0; tx_b = 0; rx_w = 0; cyc = 0;
        prev_stall = 1'b0; prev_word = '0;
        while (rx_w < NWORDS && cyc < BUDGET) begin
            if (tx_w < NWORDS) begin
                sin_valid = ($urandom_range(0, 9) < 7);
                sin       = sent[tx_w][tx_b];
                sin_sof   = (tx_b == 0);
            end else begin
                idle();
            end
            word_ready = ($urandom_range(0, 9) < 6);
            if (prev_stall) check("rand_word_stable", word, prev_word);
            if (frame_err !== 1'b0) check("rand_frame_err", frame_err, 0);
            if (sin_valid && sin_ready) begin
                if (tx_b == N - 1) begin
                    tx_b = 0;
                    tx_w++;
                end else begin
                    tx_b++;
                end
            end
            if (word_valid && word_ready) begin
                check("rand_word", word, sent[rx_w]);
                rx_w++;
            end
            prev_stall = word_valid && !word_ready;
            prev_word  = word;
            tick();
            cyc++;
        end
        idle();
        check("rand_all_received", rx_w, NWORDS);
        check("rand_all_sent", tx_w, NWORDS);
        word_ready = 1'b0;
        tick();
        check("rand_no_extra_word", word_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_word_loader.md
SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

Interface
REQ-001 SHALL have parameter N, default 8, giving the word width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port sin  input  1  serial data bit.
REQ-005 SHALL have port sin_valid  input  1  sin is valid this cycle.
REQ-006 SHALL have port sin_sof  input  1  qualifies sin as bit 0 of a new word; meaningful only with sin_valid.
REQ-007 SHALL have port sin_ready  output  1  loader accepts a serial bit this cycle.
REQ-008 SHALL have port word  output  N  assembled parallel word, intended to drive the bit-reverse/palindrome stage.
REQ-009 SHALL have port word_valid  output  1  word holds an unconsumed assembled word.
REQ-010 SHALL have port word_ready  input  1  downstream accepts word this cycle.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: a partial word was discarded.

Function
REQ-012 SHALL accept a serial bit on any cycle where sin_valid and sin_ready are both 1; no other cycle changes the shift state.
REQ-013 SHALL pack bits LSB-first: the k-th accepted bit of a word (k = 0..N-1) lands in word[k].
REQ-014 SHALL keep an internal bit count 0..N-1 plus a shift register, and a separate one-word output register (word/word_valid).
REQ-015 SHALL complete a word on the cycle it accepts bit N-1; at that edge, if word_valid==0 or word_ready==1, the completed word SHALL load into word with word_valid=1 the next cycle (latency 1 from the last bit) and the bit count SHALL return to 0.
REQ-016 SHALL, if a word completes while word_valid==1 and word_ready==0, hold the completed word in the shift register (state FULL), drive sin_ready=0, and transfer it to the output register on the first cycle with word_ready==1; word_valid SHALL stay 1 across that transfer.
REQ-017 SHALL drive sin_ready=1 in every state except FULL and reset; sin_ready SHALL be registered, with no combinational path from word_ready.
REQ-018 SHALL clear word_valid at the edge after a cycle with word_valid==1, word_ready==1 and no new word loading.
REQ-019 SHALL hold word stable while word_valid==1 and word_ready==0.
REQ-020 SHALL, on an accepted bit with sin_sof==1 and bit count != 0, discard the partial word, pulse frame_err for exactly one cycle, and treat the sof bit as bit 0 of the new word.
REQ-021 SHALL ignore sin_sof when bit count == 0; this is not an error.
REQ-022 SHALL ignore sin, sin_sof and sin_valid while sin_ready==0; no bit is lost or counted.
REQ-023 SHALL ignore word_ready while word_valid==0.
REQ-024 SHALL sustain one bit per cycle indefinitely when word_ready is held at 1; no bubble at word boundaries.

Reset
REQ-025 SHALL, on a cycle with rst==1, set bit count=0, shift register=0, word=0, word_valid=0, frame_err=0 and state to not-FULL; sin_ready SHALL be 0 during reset and 1 on the first cycle after.
REQ-026 SHALL discard any partial word, held FULL word and unconsumed output word when rst is asserted mid-operation, without pulsing frame_err.

Verification
REQ-027 N=8, word_ready=1, stream bits 1,0,1,1,0,0,0,1 on consecutive cycles -> word=8'h8D, word_valid high exactly one cycle, one cycle after the eighth bit.
REQ-028 N=8, word_ready=0, send 16 bits 8'hA5 then 8'h3C -> word=8'hA5 held, sin_ready=0 after bit 16; raise word_ready -> A5 consumed, then 3C presented with word_valid continuously 1, sin_ready returns to 1.
REQ-029 Send 3 bits, then a bit with sin_sof=1 followed by 7 more bits forming 8'hFF -> frame_err pulses once on the cycle after the sof bit, output word=8'hFF, no partial word emitted.
REQ-030 Assert rst while 5 bits are buffered and word_valid=1 -> all outputs 0 the next cycle, then the next 8 bits form a clean word.
REQ-031 Continuous random stream of 1000 words, random sin_valid and word_ready -> scoreboard matches every word in order, no loss or duplication; word stable while stalled.
